// File: rtl/ascon_pack.sv
`default_nettype none
// ============================================================================
// ascon_pack : shared types, round-constant table and FSM encoding  | Rev 1.0
// ============================================================================
package ascon_pack;

  typedef logic [0:4][63:0] type_state;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Entry r is {15-r, r}; only the last N entries are used by a p<N> permutation.
  localparam logic [0:11][7:0] c_round_const = {
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  localparam logic [3:0] c_last_round = 4'd11;

  function automatic logic [3:0] start_index(input logic [1:0] rounds);
    case (rounds)
      2'b01:   return 4'd4;
      2'b10:   return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/substitution_layer.sv
`default_nettype none
// ============================================================================
// substitution_layer : bitsliced Ascon 5-bit S-box across all 64 columns | Rev 1.0
// ============================================================================
module substitution_layer
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);

  logic [63:0] w_x0, w_x1, w_x2, w_x3, w_x4;
  logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;

  always_comb begin
    w_x0 = state_i[0] ^ state_i[4];
    w_x4 = state_i[4] ^ state_i[3];
    w_x2 = state_i[2] ^ state_i[1];
    w_x1 = state_i[1];
    w_x3 = state_i[3];

    w_t0 = ~w_x0 & w_x1;
    w_t1 = ~w_x1 & w_x2;
    w_t2 = ~w_x2 & w_x3;
    w_t3 = ~w_x3 & w_x4;
    w_t4 = ~w_x4 & w_x0;

    w_x0 = w_x0 ^ w_t1;
    w_x1 = w_x1 ^ w_t2;
    w_x2 = w_x2 ^ w_t3;
    w_x3 = w_x3 ^ w_t4;
    w_x4 = w_x4 ^ w_t0;

    w_x1 = w_x1 ^ w_x0;
    w_x0 = w_x0 ^ w_x4;
    w_x3 = w_x3 ^ w_x2;
    w_x2 = ~w_x2;

    state_o = {w_x0, w_x1, w_x2, w_x3, w_x4};
  end

endmodule
`default_nettype wire

// File: rtl/ascon_permutation_ctrl.sv
`default_nettype none
// ============================================================================
// ascon_permutation_ctrl : iterative p12/p8/p6 Ascon permutation, 1 round/cycle | Rev 1.0
// ============================================================================
module ascon_permutation_ctrl
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] rounds_i,
  input  type_state  state_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       valid_o,
  output type_state  state_o,
  output logic [3:0] round_o
);

  fsm_state_e r_fsm;
  type_state  r_state;
  logic [3:0] r_count;

  type_state w_added;
  type_state w_sub;
  type_state w_round;

  always_comb begin
    w_added       = r_state;
    w_added[2][7:0] = r_state[2][7:0] ^ c_round_const[r_count];
  end

  substitution_layer u_substitution_layer (
    .state_i (w_added),
    .state_o (w_sub)
  );

  always_comb begin
    w_round[0] = w_sub[0] ^ rotr(w_sub[0], 19) ^ rotr(w_sub[0], 28);
    w_round[1] = w_sub[1] ^ rotr(w_sub[1], 61) ^ rotr(w_sub[1], 39);
    w_round[2] = w_sub[2] ^ rotr(w_sub[2],  1) ^ rotr(w_sub[2],  6);
    w_round[3] = w_sub[3] ^ rotr(w_sub[3], 10) ^ rotr(w_sub[3], 17);
    w_round[4] = w_sub[4] ^ rotr(w_sub[4],  7) ^ rotr(w_sub[4], 41);
  end

  // Status outputs are registered alongside the FSM so no input reaches an output combinationally.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_count <= '0;
      ready_o <= 1'b1;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      round_o <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (start_i) begin
            r_fsm   <= RUN;
            r_state <= state_i;
            r_count <= start_index(rounds_i);
            round_o <= start_index(rounds_i);
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        RUN: begin
          r_state <= w_round;
          if (r_count == c_last_round) begin
            r_fsm   <= DONE;
            busy_o  <= 1'b0;
            valid_o <= 1'b1;
            round_o <= '0;
          end else begin
            r_count <= r_count + 4'd1;
            round_o <= r_count + 4'd1;
          end
        end
        DONE: begin
          r_fsm   <= IDLE;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
        end
        default: begin
          r_fsm   <= IDLE;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
          valid_o <= 1'b0;
          round_o <= '0;
        end
      endcase
    end
  end

  assign state_o = r_state;

endmodule
`default_nettype wire
